// File: rtl/counter_hex_pkg.sv
// Shared constants for counter_hex_n: 7-segment table and digit-count helper.
// Optional feature macro used by the top: COUNTER_HEX_SAT_EN.
package counter_hex_pkg;

    // Active-low segments, bit 6 = g ... bit 0 = a; entry n shows hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110, // F
        7'b0000110, // E
        7'b0100001, // d
        7'b1000110, // C
        7'b0000011, // b
        7'b0001000, // A
        7'b0010000, // 9
        7'b0000000, // 8
        7'b1111000, // 7
        7'b0000010, // 6
        7'b0010010, // 5
        7'b0011001, // 4
        7'b0110000, // 3
        7'b0100100, // 2
        7'b1111001, // 1
        7'b1000000  // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic int ndig_of(input int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One hex nibble to active-low 7-segment pattern.
// Pure combinational lookup into the shared segment table.
module seg7_decode
    import counter_hex_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/counter_hex_n.sv
// Up/down counter with clipped load, terminal value, Tc flag and hex decode.
// Define COUNTER_HEX_SAT_EN to saturate at the limits instead of wrapping.
module counter_hex_n
    import counter_hex_pkg::*;
#(
    parameter  int               WIDTH   = 8,
    parameter  logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
    localparam int               NDIG    = ndig_of(WIDTH)
) (
    input  logic                C,
    input  logic                Clr,
    input  logic                En,
    input  logic                Up,
    input  logic                Ld,
    input  logic [WIDTH-1:0]    D,
    output logic [WIDTH-1:0]    Q,
    output logic                Tc,
    output logic [7*NDIG-1:0]   HEX
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    logic             at_top, at_bot;

    assign at_top = (q_q == MAX_VAL);
    assign at_bot = (q_q == '0);

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (Ld) begin
            q_d = (D > MAX_VAL) ? MAX_VAL : D;
        end else if (En) begin
            if (Up) begin
                if (at_top) begin
                    tc_d = 1'b1;
`ifdef COUNTER_HEX_SAT_EN
                    q_d  = MAX_VAL;
`else
                    q_d  = '0;
`endif
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (at_bot) begin
                    tc_d = 1'b1;
`ifdef COUNTER_HEX_SAT_EN
                    q_d  = '0;
`else
                    q_d  = MAX_VAL;
`endif
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge C) begin
        if (Clr) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign Q  = q_q;
    assign Tc = tc_q;

    for (genvar k = 0; k < NDIG; k++) begin : g_dig
        seg7_decode u_dec (
            .nib_i (q_q[4*k +: 4]),
            .seg_o (HEX[7*k +: 7])
        );
    end

endmodule

// File: tb/tb_counter_hex_n.sv
// Scoreboard bench: 8-bit full-range and 4-bit decade counters side by side.
// Stimulus pushes model results; a monitor pops and compares after each edge.
module tb_counter_hex_n;

    logic        C = 1'b0;
    logic        Clr = 1'b0;
    logic        En = 1'b0;
    logic        Up = 1'b0;
    logic        Ld = 1'b0;
    logic [7:0]  D = '0;
    logic [7:0]  Q8;
    logic        Tc8;
    logic [13:0] HEX8;
    logic [3:0]  Q4;
    logic        Tc4;
    logic [6:0]  HEX4;

    always #5 C = ~C;

    counter_hex_n #(.WIDTH(8)) dut8 (
        .C(C), .Clr(Clr), .En(En), .Up(Up), .Ld(Ld),
        .D(D), .Q(Q8), .Tc(Tc8), .HEX(HEX8)
    );

    counter_hex_n #(.WIDTH(4), .MAX_VAL(4'd9)) dut4 (
        .C(C), .Clr(Clr), .En(En), .Up(Up), .Ld(Ld),
        .D(D[3:0]), .Q(Q4), .Tc(Tc4), .HEX(HEX4)
    );

    typedef struct {
        int q8;
        int tc8;
        int q4;
        int tc4;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mq8 = 0;
    int   mq4 = 0;

    function automatic logic [6:0] seg(input int n);
        case (n & 15)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Reference behaviour in plain integer arithmetic, modulo maxv+1.
    task automatic step(input int maxv, input int q, input int dv,
                        output int nq, output int tc);
        tc = 0;
        nq = q;
        if (Clr) begin
            nq = 0;
        end else if (Ld) begin
            nq = (dv > maxv) ? maxv : dv;
        end else if (En) begin
            if (Up) begin
                tc = (q == maxv) ? 1 : 0;
`ifdef COUNTER_HEX_SAT_EN
                nq = tc ? q : q + 1;
`else
                nq = (q + 1) % (maxv + 1);
`endif
            end else begin
                tc = (q == 0) ? 1 : 0;
`ifdef COUNTER_HEX_SAT_EN
                nq = tc ? q : q - 1;
`else
                nq = (q + maxv) % (maxv + 1);
`endif
            end
        end
    endtask

    task automatic drive(input bit c, input bit l, input bit e,
                         input bit u, input logic [7:0] d);
        exp_t x;
        int   nq;
        int   tc;
        @(negedge C);
        Clr = c;
        Ld  = l;
        En  = e;
        Up  = u;
        D   = d;
        step(255, mq8, int'(d), nq, tc);
        mq8   = nq;
        x.q8  = nq;
        x.tc8 = tc;
        step(9, mq4, int'(d[3:0]), nq, tc);
        mq4   = nq;
        x.q4  = nq;
        x.tc4 = tc;
        sbq.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge C);
            #1;
            if (sbq.size() > 0) begin
                x = sbq.pop_front();
                chk("q8", 32'(Q8), x.q8);
                chk("tc8", 32'(Tc8), x.tc8);
                chk("hex8", 32'(HEX8),
                    32'({seg(x.q8 >> 4), seg(x.q8)}));
                chk("q4", 32'(Q4), x.q4);
                chk("tc4", 32'(Tc4), x.tc4);
                chk("hex4", 32'(HEX4), 32'(seg(x.q4)));
            end
        end
    end

    initial begin : stim
        drive(1, 0, 0, 0, 8'h00);
        drive(1, 0, 0, 0, 8'h00);
        // Wrap at top of the 8-bit range.
        drive(0, 1, 0, 0, 8'hFE);
        drive(0, 0, 1, 1, 8'h00);
        drive(0, 0, 1, 1, 8'h00);
        drive(0, 0, 1, 1, 8'h00);
        // Decade wrap, clipping and down-wrap.
        drive(0, 1, 0, 0, 8'h09);
        drive(0, 0, 1, 1, 8'h00);
        drive(0, 1, 0, 0, 8'h0C);
        drive(0, 1, 0, 0, 8'h00);
        drive(0, 0, 1, 0, 8'h00);
        drive(0, 0, 0, 0, 8'h00);
        // Priority: Ld over En, Clr over Ld/En.
        drive(0, 1, 0, 0, 8'h05);
        drive(0, 1, 1, 1, 8'h20);
        drive(1, 1, 1, 1, 8'h33);
        // Direction flips.
        drive(0, 1, 0, 0, 8'h03);
        drive(0, 0, 1, 1, 8'h00);
        drive(0, 0, 1, 1, 8'h00);
        drive(0, 0, 1, 0, 8'h00);
        drive(0, 0, 1, 0, 8'h00);
        // Hex sweep of every nibble value.
        drive(0, 1, 0, 0, 8'hA5);
        for (int n = 0; n < 16; n++) begin
            drive(0, 1, 0, 0, 8'(n * 17));
        end
        // Limit behaviour (wrap or saturate depending on build).
        drive(0, 1, 0, 0, 8'hFF);
        repeat (3) drive(0, 0, 1, 1, 8'h00);
        drive(0, 1, 0, 0, 8'h00);
        repeat (2) drive(0, 0, 1, 0, 8'h00);
        // Long runs through repeated wraps.
        repeat (300) drive(0, 0, 1, 1, 8'h00);
        repeat (40) drive(0, 0, 1, 0, 8'h00);
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0),
                  1'($urandom),
                  8'($urandom));
        end
        drive(0, 0, 0, 0, 8'h00);
        repeat (3) @(posedge C);
        #2;
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0",
                     sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
